// File: rtl/mux_arb_reg.sv
// N-channel valid/ready selector (fixed select or round-robin) feeding a single
// output register that holds its word under downstream backpressure.
module mux_arb_reg #(
  parameter  int WIDTH  = 8,
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rr_en,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  input  logic                    out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_ch_q,    out_ch_d;
  logic [SEL_W-1:0] last_grant_q, last_grant_d;

  logic             grant_vld;
  logic [SEL_W-1:0] grant;
  logic [WIDTH-1:0] grant_data;
  logic             found_hi, found_lo;
  logic [SEL_W-1:0] g_hi, g_lo;
  logic             accept, xfer;

  // Round-robin splits candidates into those above the last grant (searched
  // first) and those at or below it (the wrapped tail).
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    found_hi  = 1'b0;
    found_lo  = 1'b0;
    g_hi      = '0;
    g_lo      = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (in_valid[i]) begin
        if (SEL_W'(i) > last_grant_q) begin
          if (!found_hi) begin
            found_hi = 1'b1;
            g_hi     = SEL_W'(i);
          end
        end else if (!found_lo) begin
          found_lo = 1'b1;
          g_lo     = SEL_W'(i);
        end
      end
    end
    if (rr_en) begin
      grant_vld = found_hi | found_lo;
      grant     = found_hi ? g_hi : g_lo;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          grant_vld = 1'b1;
          grant     = SEL_W'(i);
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant == SEL_W'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign accept = !out_valid_q || out_ready;
  assign xfer   = grant_vld && accept && !rst;

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[grant] = 1'b1;
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    last_grant_d = last_grant_q;
    if (xfer) begin
      out_valid_d  = 1'b1;
      out_data_d   = grant_data;
      out_ch_d     = grant;
      last_grant_d = grant;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      last_grant_q <= SEL_W'(NUM_CH - 1);
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_arb_reg.sv
// Directed bench for mux_arb_reg: fixed select, round-robin, backpressure,
// missing-valid select and mid-operation reset.
module tb_mux_arb_reg;

  localparam int WIDTH  = 8;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    rr_en;
  logic [SEL_W-1:0]        sel;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_ready;

  int total = 0;
  int bad   = 0;

  mux_arb_reg #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
    .clk      (clk),
    .rst      (rst),
    .rr_en    (rr_en),
    .sel      (sel),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ch   (out_ch),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] c);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_data"},  32'(out_data),  32'(d));
    chk({tag, "_ch"},    32'(out_ch),    32'(c));
  endtask

  initial begin
    rst = 1'b1; rr_en = 1'b0; sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    tick();
    // in_ready must stay low while reset is asserted, even with work pending
    rr_en = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    #1 chk("rst_in_ready", 32'(in_ready), 32'h0);
    tick();
    chk_out("rst_out", 1'b0, 8'h00, 2'd0);
    rst = 1'b0;

    // 1. fixed select of channel 2
    rr_en = 1'b0; sel = 2'd2; in_valid = 4'b0100; in_data = 32'h00A5_0000;
    #1 chk("t1_in_ready", 32'(in_ready), 32'h4);
    tick();
    chk_out("t1_out", 1'b1, 8'hA5, 2'd2);
    in_valid = '0;
    tick();
    chk("t1_drain", 32'(out_valid), 32'h0);

    // 2. round-robin streaming from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0; rr_en = 1'b1; in_valid = 4'b1111; in_data = 32'h1312_1110; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_out($sformatf("t2_rr%0d", i), 1'b1, 8'(8'h10 + i % 4), 2'(i % 4));
    end
    in_valid = '0;
    tick();
    chk("t2_drain", 32'(out_valid), 32'h0);

    // 3. park the pointer on channel 1, then RR over channels 1 and 3
    rr_en = 1'b0; sel = 2'd1; in_valid = 4'b0010; in_data = 32'h0000_2200;
    tick();
    chk_out("t3_prime", 1'b1, 8'h22, 2'd1);
    in_valid = '0;
    tick();
    rr_en = 1'b1; in_valid = 4'b1010; in_data = 32'h4400_2200;
    #1 chk("t3_rdy_a", 32'(in_ready), 32'h8);
    tick();
    chk_out("t3_g0", 1'b1, 8'h44, 2'd3);
    chk("t3_rdy_b", 32'(in_ready), 32'h2);
    tick();
    chk_out("t3_g1", 1'b1, 8'h22, 2'd1);
    tick();
    chk_out("t3_g2", 1'b1, 8'h44, 2'd3);
    in_valid = '0;
    tick();
    chk("t3_drain", 32'(out_valid), 32'h0);

    // 4. backpressure holds the word; no duplicate after release
    rr_en = 1'b0; sel = 2'd0; in_valid = 4'b0001; in_data = 32'h0000_003C; out_ready = 1'b0;
    tick();
    chk_out("t4_load", 1'b1, 8'h3C, 2'd0);
    sel = 2'd2; in_valid = 4'b0101; in_data = 32'h0088_0077;
    for (int i = 0; i < 5; i++) begin
      #1 chk($sformatf("t4_rdy%0d", i), 32'(in_ready), 32'h0);
      tick();
      chk_out($sformatf("t4_hold%0d", i), 1'b1, 8'h3C, 2'd0);
    end
    in_valid = '0; out_ready = 1'b1;
    tick();
    chk("t4_once", 32'(out_valid), 32'h0);

    // 5. selected channel idle while others are valid
    sel = 2'd0; in_valid = 4'b1101; in_data = 32'h6600_0055;
    tick();
    chk_out("t5_load", 1'b1, 8'h55, 2'd0);
    sel = 2'd1;
    #1 chk("t5_in_ready", 32'(in_ready), 32'h0);
    tick();
    chk("t5_drain", 32'(out_valid), 32'h0);
    tick();
    chk("t5_idle", 32'(out_valid), 32'h0);

    // 6. reset while a word is stalled; pointer returns to channel 0 priority
    rr_en = 1'b1; in_valid = 4'b0100; in_data = 32'h005A_0000;
    tick();
    chk_out("t6_load", 1'b1, 8'h5A, 2'd2);
    out_ready = 1'b0; in_valid = '0;
    tick();
    chk_out("t6_stall", 1'b1, 8'h5A, 2'd2);
    rst = 1'b1;
    tick();
    chk_out("t6_rst", 1'b0, 8'h00, 2'd0);
    rst = 1'b0; in_valid = 4'b1111; in_data = 32'h4433_2211; out_ready = 1'b1;
    #1 chk("t6_rdy", 32'(in_ready), 32'h1);
    tick();
    chk_out("t6_first", 1'b1, 8'h11, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
